// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin grant sequencer.
package arb_pkg;

    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int MAX_HOLD_DEF = 16;
    localparam int CNT_W_DEF    = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_onehot_dec.sv
// Index-to-one-hot decoder driving the shared-resource select lines.
module arb_onehot_dec
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_grant_sequencer_8.sv
// Round-robin arbiter for 8 requesters: one-cycle grant latency, hold until
// done / request drop / MAX_HOLD timeout, with one idle cycle between grants.
module rr_grant_sequencer_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W:0]   pick;
    logic             release_now;

    // Returns {found, index}; descending loop so the smallest offset from p wins.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] i;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            i = p + IDX_W'(k);
            if (r[i]) res = {1'b1, i};
        end
        return res;
    endfunction

    assign pick        = rr_pick(req, ptr);
    assign release_now = done || !req[gnt_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && pick[IDX_W]) begin
                        state     <= GRANT;
                        gnt_idx   <= pick[IDX_W-1:0];
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    // done or a dropped request outranks the timeout
                    if (release_now) begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + 1'b1;
                    end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + 1'b1;
                        timeout   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoding registered state keeps gnt glitch-free and drops it with reset.
    arb_onehot_dec u_dec (
        .idx    (gnt_idx),
        .en     (gnt_valid),
        .onehot (gnt)
    );

endmodule
